// File: rtl/ahb_sram_resp.sv
// AHB-Lite slave fronting a 32-bit SRAM array: legality check at acceptance, configurable
// OKAY wait states, two-cycle ERROR response and byte-lane merged writes.
module ahb_sram_resp #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hready,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [1:0] WaitLast = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              lo_q, lo_d;
  logic [1:0]              size_q, size_d;
  logic                    write_q, write_d;

  logic [31:0]             mem [Depth];

  logic                    accept;
  logic                    legal;
  logic                    mem_we;
  logic [3:0]              be;

  // Upper address bits alias and hburst carries no information beyond per-beat addresses.
  logic unused_bits;
  assign unused_bits = ^{hburst, haddr[31:ADDR_WIDTH+2]};

  assign accept = hsel & hready & htrans[1];

  always_comb begin
    legal = 1'b1;
    if (hsize > 3'd2) begin
      legal = 1'b0;
    end else if (hsize == 3'd1 && haddr[0]) begin
      legal = 1'b0;
    end else if (hsize == 3'd2 && haddr[1:0] != 2'b00) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StData;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        // IDLE, DATA and ERR2 all present hready_resp=1, so a new address phase may land here.
        state_d = StIdle;
        if (accept) begin
          addr_d  = haddr[ADDR_WIDTH+1:2];
          lo_d    = haddr[1:0];
          size_d  = hsize[1:0];
          write_d = hwrite;
          cnt_d   = 2'd0;
          if (!legal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StData;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      lo_q    <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    unique case (size_q)
      2'd0:    be = 4'b0001 << lo_q;
      2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign mem_we = hresetn && (state_q == StData) && write_q;

  // Array is deliberately not reset.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    hready_resp = 1'b1;
    hresp       = 2'd0;
    hrdata      = 32'd0;
    case (state_q)
      StWait: hready_resp = 1'b0;
      StData: begin
        // Combinational read sees a write committed on the previous edge (read-after-write).
        if (!write_q) begin
          hrdata = mem[addr_q];
        end
      end
      StErr1: begin
        hready_resp = 1'b0;
        hresp       = 2'd1;
      end
      StErr2: hresp = 2'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_resp.sv
// Scoreboard bench: a pipelined AHB master queues the expected data-phase response of every
// beat; a negedge monitor pops and checks stall count, hresp and hrdata on completion.
module tb_ahb_sram_resp;

  localparam int unsigned AW = 10;

  logic        hclk;
  logic        hresetn;
  logic        hsel_bus;
  logic        use_w2;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;

  logic        rdy0, rdy2, rdy_mux;
  logic [1:0]  resp0, resp2, resp_mux;
  logic [31:0] rdata0, rdata2, rdata_mux;

  assign rdy_mux   = use_w2 ? rdy2 : rdy0;
  assign resp_mux  = use_w2 ? resp2 : resp0;
  assign rdata_mux = use_w2 ? rdata2 : rdata0;

  ahb_sram_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel_bus & ~use_w2),
    .hready      (rdy_mux),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .htrans      (htrans),
    .hburst      (hburst),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hready_resp (rdy0),
    .hresp       (resp0),
    .hrdata      (rdata0)
  );

  ahb_sram_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel_bus & use_w2),
    .hready      (rdy_mux),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .htrans      (htrans),
    .hburst      (hburst),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hready_resp (rdy2),
    .hresp       (resp2),
    .hrdata      (rdata2)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int          tag;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          tag = 0;
  int          cur_w = 0;
  logic [31:0] pend_wdata = 32'd0;

  localparam logic [1:0] TrIdle = 2'd0, TrBusy = 2'd1, TrNseq = 2'd2, TrSeq = 2'd3;

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s beat%0d: got 0x%08h required 0x%08h", name, id, got, exp);
    end
  endtask

  // Drive one address phase; it stays on the bus until accepted on an edge with hready=1.
  task automatic beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [1:0] eresp,
                      input logic [31:0] erdata, input int ewaits);
    logic rdy;
    int   n;
    exp_t e;
    hsel_bus = 1'b1;
    htrans   = tr;
    hwrite   = wr;
    hsize    = sz;
    haddr    = a;
    hwdata   = pend_wdata;
    rdy      = 1'b0;
    n        = 0;
    while (!rdy && n < 20) begin
      @(negedge hclk);
      rdy = rdy_mux;
      @(posedge hclk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout beat%0d: got no hready within %0d cycles", tag, n);
    end else begin
      e.tag   = tag;
      e.resp  = eresp;
      e.rdata = erdata;
      e.waits = ewaits;
      sb.push_back(e);
    end
    pend_wdata = wd;
    tag++;
    #1;
  endtask

  task automatic wr(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    beat(tr, 1'b1, sz, a, d, 2'd0, 32'd0, cur_w);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    beat(TrNseq, 1'b0, 3'd2, a, 32'd0, 2'd0, exp, cur_w);
  endtask

  task automatic nop(input logic [1:0] tr, input logic [31:0] a);
    beat(tr, 1'b0, 3'd2, a, 32'd0, 2'd0, 32'd0, 0);
  endtask

  task automatic bad(input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] d);
    beat(TrNseq, w, sz, a, d, 2'd1, 32'd0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge hclk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding data phases required 0", sb.size());
    end
  endtask

  // Monitor: count stall cycles of the head data phase and check it when hready_resp rises.
  int   stalls = 0;
  logic stall_resp_bad = 1'b0;
  exp_t mon_e;

  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      if (!rdy_mux) begin
        stalls++;
        if (resp_mux !== sb[0].resp) stall_resp_bad = 1'b1;
      end else begin
        mon_e = sb.pop_front();
        check("wait_cycles", mon_e.tag, 32'(stalls), 32'(mon_e.waits));
        check("hresp", mon_e.tag, 32'(resp_mux), 32'(mon_e.resp));
        check("hrdata", mon_e.tag, rdata_mux, mon_e.rdata);
        if (mon_e.waits > 0) begin
          check("stall_hresp_bad", mon_e.tag, 32'(stall_resp_bad), 32'd0);
        end
        stalls         = 0;
        stall_resp_bad = 1'b0;
      end
    end
  end

  initial begin
    hresetn  = 1'b0;
    hsel_bus = 1'b0;
    use_w2   = 1'b0;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    htrans   = TrIdle;
    hburst   = 3'd0;
    haddr    = 32'd0;
    hwdata   = 32'd0;

    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check("reset_hready_resp_w0", -1, 32'(rdy0), 32'd1);
    check("reset_hresp_w0", -1, 32'(resp0), 32'd0);
    check("reset_hrdata_w0", -1, rdata0, 32'd0);
    check("reset_hready_resp_w2", -1, 32'(rdy2), 32'd1);
    check("reset_hresp_w2", -1, 32'(resp2), 32'd0);
    check("reset_hrdata_w2", -1, rdata2, 32'd0);
    @(posedge hclk);
    #1;

    // Zero wait states: read-after-write, then lane merge.
    wr(TrNseq, 3'd2, 32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF);
    wr(TrNseq, 3'd2, 32'h20, 32'h11223344);
    wr(TrNseq, 3'd0, 32'h22, 32'h00AA0000);
    wr(TrNseq, 3'd1, 32'h20, 32'h0000BBCC);
    rd(32'h20, 32'h11AABBCC);

    // Illegal transfers: misaligned word write, hsize=3, odd halfword write.
    bad(1'b1, 3'd2, 32'h22, 32'h55555555);
    bad(1'b0, 3'd3, 32'h20, 32'h0);
    bad(1'b1, 3'd1, 32'h21, 32'hFFFFFFFF);
    rd(32'h20, 32'h11AABBCC);

    // INCR4 with BUSY/IDLE interleaved, then aliased read.
    wr(TrNseq, 3'd2, 32'h40, 32'd1);
    nop(TrBusy, 32'h44);
    wr(TrSeq, 3'd2, 32'h44, 32'd2);
    nop(TrIdle, 32'h48);
    wr(TrNseq, 3'd2, 32'h48, 32'd3);
    nop(TrBusy, 32'h4C);
    wr(TrSeq, 3'd2, 32'h4C, 32'd4);
    rd(32'h40 + (32'd1 << (AW + 2)), 32'd1);
    rd(32'h4C, 32'd4);
    rd(32'h44, 32'd2);
    nop(TrIdle, 32'h0);
    drain();

    // Two wait states on the second instance.
    use_w2 = 1'b1;
    cur_w  = 2;
    wr(TrNseq, 3'd2, 32'h20, 32'h11AABBCC);
    rd(32'h20, 32'h11AABBCC);
    wr(TrNseq, 3'd0, 32'h23, 32'h77000000);
    rd(32'h20, 32'h77AABBCC);
    bad(1'b0, 3'd4, 32'h20, 32'h0);
    rd(32'h20, 32'h77AABBCC);
    nop(TrIdle, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
